// File: rtl/mem_stage_if.sv
// MEM stage pipeline interface: EX->MEM handshake and bus, MEM->WB handshake
// and bus, data SRAM response channel, WB cancel, and the ID bypass/flush hints.
// The "slave" modport is the MEM stage's own view; "master" is its environment.
interface mem_stage_if;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [193:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [157:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_cancel;
  logic [38:0]  ms_fwd_bus;
  logic         ms_flush_hint;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata, ws_cancel,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_flush_hint
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus,
           data_sram_data_ok, data_sram_rdata, ws_cancel,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_bus, ms_flush_hint
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its data SRAM response,
// buffers read data while WB stalls, extracts load data, and drops responses
// owed to instructions that WB has cancelled.
//
// Response tracker states:
//   state     | meaning
//   S_IDLE    | no response outstanding
//   S_WAIT    | current instruction's request is outstanding, response unseen
//   S_DISCARD | a response is owed to a cancelled instruction; drop it
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} trk_e;

  trk_e         r_state;
  trk_e         w_state_nxt;
  logic         r_valid;
  logic [193:0] r_bus;
  logic         r_rbuf_valid;
  logic [31:0]  r_rbuf;

  // field views of the held instruction
  logic         w_req;
  logic [2:0]   w_ld_type;
  logic [31:0]  w_rt_value;
  logic         w_tlbwi;
  logic         w_tlbr;
  logic         w_ex;
  logic [1:0]   w_addr;
  logic         w_eret;
  logic [3:0]   w_rf_we;
  logic [4:0]   w_dest;
  logic [31:0]  w_result;

  assign w_req      = r_bus[193];
  assign w_ld_type  = r_bus[192:190];
  assign w_rt_value = r_bus[189:158];
  assign w_tlbwi    = r_bus[156];
  assign w_tlbr     = r_bus[155];
  assign w_ex       = r_bus[154];
  assign w_addr     = r_bus[117:116];
  assign w_eret     = r_bus[115];
  assign w_rf_we    = r_bus[72:69];
  assign w_dest     = r_bus[68:64];
  assign w_result   = r_bus[63:32];

  logic w_in_needs;
  logic w_cur_needs;
  logic w_data_ok_live;
  logic w_ready_go;
  logic w_to_ws_valid;
  logic w_allowin;
  logic w_accept;
  logic w_leave;
  logic w_is_load;

  // An incoming instruction owes us a response only if it issued a request
  // and did not already fault in an earlier stage.
  assign w_in_needs     = bus.es_to_ms_bus[193] && !bus.es_to_ms_bus[154];
  assign w_cur_needs    = r_valid && w_req && !w_ex;
  // A response belongs to the held instruction only while tracking it in S_WAIT.
  assign w_data_ok_live = bus.data_sram_data_ok && (r_state == S_WAIT);
  assign w_ready_go     = !w_req || w_ex || w_data_ok_live || r_rbuf_valid;
  assign w_to_ws_valid  = r_valid && w_ready_go;
  assign w_allowin      = !r_valid || (w_ready_go && bus.ws_allowin);
  assign w_accept       = bus.es_to_ms_valid && w_allowin && !bus.ws_cancel;
  assign w_leave        = w_to_ws_valid && bus.ws_allowin;
  assign w_is_load      = (w_ld_type != 3'd7) && !w_ex;

  // stage valid bit; a WB cancel wins over a simultaneous accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_valid <= 1'b0;
    else if (bus.ws_cancel) r_valid <= 1'b0;
    else if (w_allowin)     r_valid <= bus.es_to_ms_valid;
  end

  // capture the EX payload on handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  r_bus <= '0;
    else if (bus.es_to_ms_valid && w_allowin)   r_bus <= bus.es_to_ms_bus;
  end

  // hold read data that arrived while WB was stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rbuf_valid <= 1'b0;
      r_rbuf       <= '0;
    end else if (bus.ws_cancel || w_leave) begin
      r_rbuf_valid <= 1'b0;
    end else if (w_data_ok_live && !bus.ws_allowin) begin
      r_rbuf_valid <= 1'b1;
      r_rbuf       <= bus.data_sram_rdata;
    end
  end

  // response tracker state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // response tracker next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_in_needs) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.data_sram_data_ok)
          w_state_nxt = (w_accept && w_in_needs) ? S_WAIT : S_IDLE;
        else if (bus.ws_cancel)
          w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        // The stale response retires; whoever is now in MEM waits for its own.
        if (bus.data_sram_data_ok) begin
          if (w_cur_needs)
            w_state_nxt = bus.ws_cancel ? S_DISCARD : S_WAIT;
          else if (w_accept && w_in_needs)
            w_state_nxt = S_WAIT;
          else
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final;

  assign w_rdata = r_rbuf_valid ? r_rbuf : bus.data_sram_rdata;
  assign w_byte  = w_rdata[{w_addr, 3'b000} +: 8];
  assign w_half  = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];

  // load data extraction, including unaligned lwl/lwr merges
  always_comb begin
    w_load_data = w_rdata;
    case (w_ld_type)
      3'd0: w_load_data = w_rdata;
      3'd1: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd2: w_load_data = {24'd0, w_byte};
      3'd3: w_load_data = {{16{w_half[15]}}, w_half};
      3'd4: w_load_data = {16'd0, w_half};
      3'd5: begin
        case (w_addr)
          2'd0:    w_load_data = {w_rdata[7:0],  w_rt_value[23:0]};
          2'd1:    w_load_data = {w_rdata[15:0], w_rt_value[15:0]};
          2'd2:    w_load_data = {w_rdata[23:0], w_rt_value[7:0]};
          default: w_load_data = w_rdata;
        endcase
      end
      3'd6: begin
        case (w_addr)
          2'd0:    w_load_data = w_rdata;
          2'd1:    w_load_data = {w_rt_value[31:24], w_rdata[31:8]};
          2'd2:    w_load_data = {w_rt_value[31:16], w_rdata[31:16]};
          default: w_load_data = {w_rt_value[31:8],  w_rdata[31:24]};
        endcase
      end
      default: w_load_data = w_result;
    endcase
  end

  assign w_final = w_is_load ? w_load_data : w_result;

  logic w_fwd_valid;
  assign w_fwd_valid = r_valid && (w_rf_we != 4'd0) && !w_ex;

  assign bus.ms_allowin     = w_allowin;
  assign bus.ms_to_ws_valid = w_to_ws_valid;
  assign bus.ms_to_ws_bus   = {r_bus[157:64], w_final, r_bus[31:0]};
  assign bus.ms_fwd_bus     = {w_fwd_valid, w_fwd_valid && w_is_load && !w_ready_go,
                               w_dest, w_final};
  assign bus.ms_flush_hint  = r_valid && (w_ex || w_eret || w_tlbwi || w_tlbr);

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ws_allowin, input, 1, WB stage can accept an instruction this cycle.
REQ-004 SHALL have port ms_allowin, output, 1, MEM stage can accept an instruction this cycle.
REQ-005 SHALL have port es_to_ms_valid, input, 1, EX stage offers an instruction.
REQ-006 SHALL have port es_to_ms_bus, input, 194, packed {ms_req[193], ld_type[192:190], rt_value[189:158], wb_fields[157:0]}.
- wb_fields layout: {tlb_refill, tlbwi, tlbr, ex, exccode[5], bd, badvaddr[32], eret, mtc0, cp0_addr[8], cp0_wdata[32], res_from_cp0, rf_we[4], dest[5], result[32], pc[32]}.
REQ-007 SHALL have port ms_to_ws_valid, output, 1, instruction offered to WB.
REQ-008 SHALL have port ms_to_ws_bus, output, 158, wb_fields with result replaced by load data for loads.
REQ-009 SHALL have port data_sram_data_ok, input, 1, one-cycle pulse: read/write response returned.
REQ-010 SHALL have port data_sram_rdata, input, 32, read data; valid only with data_ok.
REQ-011 SHALL have port ws_cancel, input, 1, WB flush (exception, eret, tlbwi, tlbr).
REQ-012 SHALL have port ms_fwd_bus, output, 39, {fwd_valid, fwd_blocked, dest[5], value[32]} for ID bypass.
REQ-013 SHALL have port ms_flush_hint, output, 1, valid MEM instruction carries ex, eret, tlbwi or tlbr; EX suppresses new stores.

Function
REQ-014 SHALL register es_to_ms_bus when es_to_ms_valid && ms_allowin.
REQ-015 SHALL compute ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-016 SHALL set ms_ready_go = !ms_req || ex || data_ok_seen.
- data_ok_seen = data_sram_data_ok this cycle (not discarded) || rbuf_valid.
REQ-017 SHALL capture data_sram_rdata into rbuf and set rbuf_valid when data_ok arrives for the current instruction and ws_allowin=0.
- rbuf_valid clears when the instruction leaves MEM.
REQ-018 SHALL implement a 3-state response tracker: IDLE, WAIT (request outstanding, response unseen), DISCARD (response owed to a cancelled instruction).
- Transitions: IDLE->WAIT on accepting ms_req=1 && ex=0.
- WAIT->IDLE on data_ok.
- WAIT->DISCARD on ws_cancel without data_ok.
- DISCARD->IDLE on data_ok.
REQ-019 SHALL drop a data_ok in DISCARD with no effect on rbuf or the bus; a new instruction accepted meanwhile is not ready until its own data_ok.
REQ-020 SHALL clear ms_valid and rbuf_valid on ws_cancel, with priority over a simultaneous accept.
REQ-021 SHALL select load data from ld_type and addr[1:0] = badvaddr[1:0]:
- 0 lw: word.
- 1 lb / 2 lbu: selected byte, sign/zero extended.
- 3 lh / 4 lhu: halfword at addr[1], sign/zero extended.
- 5 lwl: merge high bytes of rdata over rt_value per addr.
- 6 lwr: merge low bytes of rdata over rt_value per addr.
- 7: no load; result passes through.
REQ-022 SHALL source load data from rbuf when rbuf_valid, else from data_sram_rdata.
REQ-023 SHALL drive fwd_valid = ms_valid && rf_we!=0 && !ex.
- fwd_blocked = fwd_valid && load && !ms_ready_go.
- value = final result.
REQ-024 SHALL pass stores through (ms_req=1, ld_type=7) after their data_ok; result unchanged.

Reset
REQ-025 SHALL, on reset assertion, immediately clear ms_valid and rbuf_valid, set the tracker to IDLE, and drive ms_to_ws_valid=0, ms_fwd_bus fwd_valid=0, ms_flush_hint=0, ms_allowin=1.
REQ-026 SHALL, on reset mid-transaction, forget any outstanding response; the response is not tracked after release.

Verification
REQ-027 Bench SHALL cover: lb with addr low=3, rdata=0x80FF1234 -> result 0xFFFFFF80; lbu -> 0x00000080.
REQ-028 Bench SHALL cover: lwl addr low=1, rt=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344; lwr addr low=1 -> 0x11AABBCC.
REQ-029 Bench SHALL cover: load, data_ok with ws_allowin=0 for 3 cycles -> rbuf holds value; ms_to_ws_valid held at 1; correct data delivered when ws_allowin=1.
REQ-030 Bench SHALL cover: ws_cancel while WAIT, next load accepted, first data_ok=0xDEAD -> discarded; second data_ok=0xBEEF -> delivered 0xBEEF.
REQ-031 Bench SHALL cover: ex=1 with ms_req=1 -> no WAIT; forwarded to WB next cycle; ms_flush_hint=1; fwd_valid=0.
REQ-032 Bench SHALL cover: reset asserted in WAIT -> outputs cleared asynchronously; post-reset load completes normally.
